tap_classifier: RTL and testbench
=================================

Name: tap_classifier

Overview:
- Consumes the single-cycle press pulses produced by the debounce-and-pulse stage.
- Groups presses that fall within a timeout window into one tap gesture (single, double, triple, ...).
- Emits one registered event per gesture, carrying the tap count.
- Sits between the button front-end and the control logic (camera/mode select), so one physical button can drive several actions.

Parameters:
- WINDOW_CYCLES, 50_000_000: maximum idle gap between presses in one gesture, in clk cycles (0.5 s at 100 MHz). Must be >= 2.
- MAX_TAPS, 3: tap count at which a gesture closes immediately, without waiting for the timeout. Must be >= 2.
- Derived widths:
  - TIMER_W = $clog2(WINDOW_CYCLES).
  - CNT_W = $clog2(MAX_TAPS+1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- press_in  input  1  press pulse from the button front-end.
- tap_valid_out  output  1  one-cycle strobe: a gesture has completed.
- tap_count_out  output  CNT_W  tap count of the last completed gesture. Held until the next strobe.
- tap_onehot_out  output  MAX_TAPS  one-hot of the count: bit n-1 is high for n taps. Valid only while tap_valid_out is high, otherwise 0.
- busy_out  output  1  high while a gesture is open (state COUNTING).

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, timer=0, count=0.
  - tap_valid_out=0, tap_count_out=0, tap_onehot_out=0, busy_out=0.
  - Any in-progress gesture is discarded, with no emission.
  - rst has priority over press_in.
- Press counting: every cycle with press_in=1 counts as one press. The upstream guarantees single-cycle pulses. A held level counts once per cycle, and the block makes no attempt to correct this.
- All outputs are registered. tap_valid_out and tap_onehot_out default to 0 every cycle unless set by an emission.
- State IDLE:
  - press_in=1: count<=1, timer<=0, go to COUNTING.
  - Otherwise: hold.
- State COUNTING, evaluated in priority order:
  1. press_in=1 and count+1 == MAX_TAPS: emit with count MAX_TAPS, go to IDLE, count<=0.
  2. press_in=1: count<=count+1, timer<=0, stay in COUNTING.
  3. timer == WINDOW_CYCLES-1: emit with the current count, go to IDLE, count<=0, timer<=0.
  4. Otherwise: timer<=timer+1.
- Emit (registered):
  - tap_valid_out<=1.
  - tap_count_out<=n.
  - tap_onehot_out<=1<<(n-1).
- Timeout latency: a gesture whose last press is in cycle k strobes in cycle k+WINDOW_CYCLES+1.
- MAX_TAPS latency: the strobe appears in the cycle after the MAX_TAPS-th press.
- Simultaneous press and timeout (press in the cycle where timer == WINDOW_CYCLES-1): the press wins. It is counted and the window restarts.
- Press in the cycle where tap_valid_out is high: the state is already IDLE, so the press starts a new gesture with count=1. The previous emission is unaffected.
- busy_out is 1 exactly while state == COUNTING. It is 0 in the strobe cycle.
- count never exceeds MAX_TAPS. timer never exceeds WINDOW_CYCLES-1. No wrap-around is possible.

Test Plan:
All scenarios use WINDOW_CYCLES=8, MAX_TAPS=3, and rst deasserted from cycle 2.
- Single tap: press in cycle 10 -> busy_out high cycles 11-18; tap_valid_out high only in cycle 19, tap_count_out=1, tap_onehot_out=3'b001; count still 1 in cycle 40.
- Double tap: presses in cycles 10 and 15 -> single strobe in cycle 24, tap_count_out=2, onehot=3'b010; no strobe in cycle 19.
- Boundary gap:
  - Presses in cycles 10 and 18 (simultaneous with timeout) -> one strobe, cycle 27, count=2.
  - Presses in cycles 10 and 19 -> strobes in cycle 19 (count=1) and cycle 28 (count=1).
- MAX_TAPS early close: presses in cycles 10, 12, 14 -> strobe in cycle 15, count=3, onehot=3'b100; busy_out low in cycle 15; no further strobe through cycle 40.
- Reset mid-gesture: press in cycle 10, rst=1 in cycle 13 -> busy_out=0 from cycle 14; no strobe through cycle 40; tap_count_out=0.
- Press during rst: press_in=1 and rst=1 both in cycle 5 -> no gesture starts; busy_out stays 0.

Source files
------------

// File: rtl/tap_classifier_if.sv
// Press/gesture signal bundle between the button front-end, the tap classifier
// and the control logic that consumes tap gestures.
interface tap_classifier_if #(
  parameter int MAX_TAPS = 3
);
  localparam int CNT_W = $clog2(MAX_TAPS + 1);

  logic                press_in;
  logic                tap_valid_out;
  logic [CNT_W-1:0]    tap_count_out;
  logic [MAX_TAPS-1:0] tap_onehot_out;
  logic                busy_out;

  modport master (
    output press_in,
    input  tap_valid_out, tap_count_out, tap_onehot_out, busy_out
  );

  modport slave (
    input  press_in,
    output tap_valid_out, tap_count_out, tap_onehot_out, busy_out
  );
endinterface

// File: rtl/tap_classifier.sv
// Groups press pulses separated by less than WINDOW_CYCLES idle cycles into one
// tap gesture and emits a single registered strobe with the tap count.
module tap_classifier #(
  parameter int WINDOW_CYCLES = 50_000_000,
  parameter int MAX_TAPS      = 3
) (
  input  logic            clk,
  input  logic            rst,
  tap_classifier_if.slave tap
);
  localparam int TIMER_W = $clog2(WINDOW_CYCLES);
  localparam int CNT_W   = $clog2(MAX_TAPS + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_CLOSE  = CNT_W'(MAX_TAPS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_TAPS);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   count;

  // NOTE: sequential state is written with <= so every branch below sees the
  // pre-edge values of state, timer and count.
  always_ff @(posedge clk) begin
    tap.tap_valid_out  <= 1'b0;
    tap.tap_onehot_out <= '0;
    if (rst) begin
      state             <= IDLE;
      timer             <= '0;
      count             <= '0;
      tap.tap_count_out <= '0;
      tap.busy_out      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tap.press_in) begin
            state        <= COUNTING;
            count        <= CNT_W'(1);
            timer        <= '0;
            tap.busy_out <= 1'b1;
          end
        end
        COUNTING: begin
          if (tap.press_in && count == CNT_CLOSE) begin
            // Final allowed press closes the gesture without waiting out the window.
            state              <= IDLE;
            count              <= '0;
            timer              <= '0;
            tap.busy_out       <= 1'b0;
            tap.tap_valid_out  <= 1'b1;
            tap.tap_count_out  <= CNT_MAX;
            tap.tap_onehot_out <= MAX_TAPS'(1) << (MAX_TAPS - 1);
          end else if (tap.press_in) begin
            // A press on the last window cycle still wins over the timeout.
            count <= count + 1'b1;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state              <= IDLE;
            count              <= '0;
            timer              <= '0;
            tap.busy_out       <= 1'b0;
            tap.tap_valid_out  <= 1'b1;
            tap.tap_count_out  <= count;
            tap.tap_onehot_out <= MAX_TAPS'(1) << (count - 1'b1);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          tap.busy_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tap_classifier.sv
// Scenario table for tap_classifier (WINDOW_CYCLES=8, MAX_TAPS=3): each row gives
// per-cycle press/rst stimulus, the expected busy profile and the expected strobes.
module tb_tap_classifier;
  localparam int WIN     = 8;
  localparam int MAXT    = 3;
  localparam int NCYC    = 42;
  localparam int NVEC    = 8;

  typedef struct {
    string       name;
    logic [63:0] press;
    logic [63:0] rst_m;
    logic [63:0] busy;
    int          ev0_cyc;
    int          ev0_cnt;
    int          ev1_cyc;
    int          ev1_cnt;
    int          final_cnt;
  } vec_t;

  typedef struct {
    int cyc;
    int cnt;
  } event_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NVEC];
  event_t sb [$];

  tap_classifier_if #(.MAX_TAPS(MAXT)) tif ();

  tap_classifier #(
    .WINDOW_CYCLES(WIN),
    .MAX_TAPS     (MAXT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tap(tif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit1(input int i);
    logic [63:0] m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    event_t e;
    sb.delete();
    if (v.ev0_cyc > 0) begin e.cyc = v.ev0_cyc; e.cnt = v.ev0_cnt; sb.push_back(e); end
    if (v.ev1_cyc > 0) begin e.cyc = v.ev1_cyc; e.cnt = v.ev1_cnt; sb.push_back(e); end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst          = v.rst_m[c];
      tif.press_in = v.press[c];
      @(negedge clk);
      if (c < 2) continue;
      if (c == 2) check({v.name, " reset count"}, 64'(tif.tap_count_out), 64'd0);
      check($sformatf("%s busy c%0d", v.name, c), 64'(tif.busy_out), 64'(v.busy[c]));
      if (tif.tap_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check($sformatf("%s unexpected strobe c%0d", v.name, c), 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("%s strobe cycle", v.name), 64'(c), 64'(e.cyc));
          check($sformatf("%s strobe count", v.name), 64'(tif.tap_count_out), 64'(e.cnt));
          check($sformatf("%s strobe onehot", v.name), 64'(tif.tap_onehot_out),
                64'(1) << (e.cnt - 1));
        end
      end else begin
        check($sformatf("%s onehot idle c%0d", v.name, c), 64'(tif.tap_onehot_out), 64'd0);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s missing strobe at c%0d", v.name, e.cyc), 64'd0, 64'd1);
    end
    check({v.name, " held count"}, 64'(tif.tap_count_out), 64'(v.final_cnt));
  endtask

  initial begin
    logic [63:0] rst_std;
    rst_std = bits(0, 1);

    vecs[0] = '{"single",   bit1(10), rst_std, bits(11, 18),
                19, 1, 0, 0, 1};
    vecs[1] = '{"double",   bit1(10) | bit1(15), rst_std, bits(11, 23),
                24, 2, 0, 0, 2};
    vecs[2] = '{"gap8",     bit1(10) | bit1(18), rst_std, bits(11, 26),
                27, 2, 0, 0, 2};
    vecs[3] = '{"gap9",     bit1(10) | bit1(19), rst_std, bits(11, 18) | bits(20, 27),
                19, 1, 28, 1, 1};
    vecs[4] = '{"triple",   bit1(10) | bit1(12) | bit1(14), rst_std, bits(11, 14),
                15, 3, 0, 0, 3};
    vecs[5] = '{"rst_mid",  bit1(10), rst_std | bit1(13), bits(11, 13),
                0, 0, 0, 0, 0};
    vecs[6] = '{"rst_press", bit1(5), rst_std | bit1(5), '0,
                0, 0, 0, 0, 0};
    vecs[7] = '{"press_on_strobe", bits(10, 13), rst_std, bits(11, 12) | bits(14, 21),
                13, 3, 22, 1, 1};

    tif.press_in = 1'b0;
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
